// File: rtl/lambert_shade_stream_pkg.sv
// Shared fixed-point vector types and arithmetic helpers for the shading stage.
// fp_t is signed Q8.24. A vec3 travels as {x, y, z}, with x in the top 32 bits.
package lambert_shade_stream_pkg;

  typedef logic signed [31:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam fp_t FP_ONE  = 32'sh01000000;
  localparam fp_t FP_ZERO = 32'sh00000000;

  // Each full 64-bit product is rescaled by >>>24 before the terms are summed.
  // The sum is kept to 32 bits, which equals truncating a wider sum.
  function automatic fp_t vec3_dot(input vec3_t a, input vec3_t b);
    logic signed [63:0] px;
    logic signed [63:0] py;
    logic signed [63:0] pz;
    fp_t                sum;
    px  = 64'(a.x) * 64'(b.x);
    py  = 64'(a.y) * 64'(b.y);
    pz  = 64'(a.z) * 64'(b.z);
    sum = fp_t'(px >>> 24) + fp_t'(py >>> 24) + fp_t'(pz >>> 24);
    return sum;
  endfunction

  // Limits a value to the range [0, 1.0].
  function automatic fp_t clamp_unit(input fp_t v);
    fp_t r;
    if (v < FP_ZERO) begin
      r = FP_ZERO;
    end else if (v > FP_ONE) begin
      r = FP_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Scales an 8-bit channel by a non-negative intensity and saturates at 255.
  // When i is exactly 1.0, the result equals base.
  function automatic logic [7:0] scale_channel(input logic [7:0] base, input fp_t i);
    logic [39:0] p;
    logic [7:0]  r;
    p = {32'd0, base} * {8'd0, i};
    if (p[39:32] != 8'd0) begin
      r = 8'hFF;
    end else begin
      r = p[31:24];
    end
    return r;
  endfunction

endpackage

// File: rtl/lambert_shade_stream_raster_counter.sv
// Raster position counter. It advances one pixel per output handshake and
// wraps at the end of each line and at the end of each frame.
module lambert_shade_stream_raster_counter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int XW    = $clog2(H_RES),
  parameter int YW    = (V_RES > 1) ? $clog2(V_RES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sof,
  output logic          eol
);

  // Step x on each advance. When x wraps to 0, step y, which wraps at the last line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == XW'(H_RES - 1)) begin
        x <= '0;
        if (y == YW'(V_RES - 1)) begin
          y <= '0;
        end else begin
          y <= y + YW'(1);
        end
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign sof = (x == '0) && (y == '0);
  assign eol = (x == XW'(H_RES - 1));

endmodule

// File: rtl/lambert_shade_stream.sv
// Lambertian shading stage with a ready/valid stream on both sides.
// The datapath runs: input register -> dot product -> intensity -> colour/output.
// Every stage moves together under one shared advance enable.
module lambert_shade_stream
  import lambert_shade_stream_pkg::*;
#(
  parameter int          H_RES    = 640,
  parameter int          V_RES    = 480,
  parameter logic [31:0] AMBIENT  = 32'h0019999A,
  parameter logic [31:0] KD       = 32'h00E66666,
  parameter logic [23:0] COLOR0   = 24'hFF8000,
  parameter logic [23:0] COLOR1   = 24'h2060FF,
  parameter logic [23:0] BG_COLOR = 24'h101010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic        hit_in,
  input  logic        obj_sel,
  input  logic [95:0] normal,
  input  logic [95:0] light_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_rgb,
  output logic        out_sof,
  output logic        out_eol
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic          running;
  logic          en;
  logic          s0_valid, s0_hit, s0_obj;
  vec3_t         s0_n, s0_l;
  logic          s1_valid, s1_hit, s1_obj;
  fp_t           s1_d;
  logic          s2_valid, s2_hit;
  fp_t           s2_i;
  rgb888_t       s2_color;
  fp_t           dc;
  logic signed [63:0] kd_prod;
  logic signed [63:0] i_sum;
  fp_t           i_next;
  rgb888_t       color_next;
  rgb888_t       pix_rgb;
  logic          sof_sel, eol_sel;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic          rc_sof, rc_eol;

  // The whole pipeline freezes only while a presented pixel is being refused.
  assign en       = !(out_valid && !out_ready);
  assign ready_in = running && en;

  // Intake stays closed until the first clock edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
    end else begin
      running <= 1'b1;
    end
  end

  // Capture the incoming beat. An empty slot moves forward as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_hit   <= 1'b0;
      s0_obj   <= 1'b0;
      s0_n     <= '0;
      s0_l     <= '0;
    end else if (en) begin
      s0_valid <= valid_in && ready_in;
      s0_hit   <= hit_in;
      s0_obj   <= obj_sel;
      s0_n     <= vec3_t'(normal);
      s0_l     <= vec3_t'(light_vec);
    end
  end

  // Dot product of the surface normal and the light vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_obj   <= 1'b0;
      s1_d     <= FP_ZERO;
    end else if (en) begin
      s1_valid <= s0_valid;
      s1_hit   <= s0_hit;
      s1_obj   <= s0_obj;
      s1_d     <= vec3_dot(s0_n, s0_l);
    end
  end

  // Compute intensity = ambient + kd * clamp(d), held within [0, 1.0], and pick the base colour.
  always_comb begin
    dc      = clamp_unit(s1_d);
    kd_prod = 64'(fp_t'(KD)) * 64'(dc);
    i_sum   = 64'(fp_t'(AMBIENT)) + (kd_prod >>> 24);
    if (i_sum > 64'(FP_ONE)) begin
      i_next = FP_ONE;
    end else if (i_sum < 64'sd0) begin
      i_next = FP_ZERO;
    end else begin
      i_next = fp_t'(i_sum);
    end
    if (s1_obj) begin
      color_next = rgb888_t'(COLOR1);
    end else begin
      color_next = rgb888_t'(COLOR0);
    end
  end

  // Register the intensity and the selected colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_hit   <= 1'b0;
      s2_i     <= FP_ZERO;
      s2_color <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_hit   <= s1_hit;
      s2_i     <= i_next;
      s2_color <= color_next;
    end
  end

  // Shade the pixel, or use the background colour on a miss. Also find its raster position.
  // With en high, a valid output pixel is leaving on this edge. The counter then
  // still points at that departing pixel, so the incoming pixel takes the next position.
  always_comb begin
    if (s2_hit) begin
      pix_rgb.r = scale_channel(s2_color.r, s2_i);
      pix_rgb.g = scale_channel(s2_color.g, s2_i);
      pix_rgb.b = scale_channel(s2_color.b, s2_i);
    end else begin
      pix_rgb = rgb888_t'(BG_COLOR);
    end
    if (out_valid) begin
      sof_sel = (x_pos == XW'(H_RES - 1)) && (y_pos == YW'(V_RES - 1));
      eol_sel = (x_pos == XW'(H_RES - 2));
    end else begin
      sof_sel = rc_sof;
      eol_sel = rc_eol;
    end
  end

  // Output register. The frame markers are registered together with their pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rgb   <= 24'h000000;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_rgb <= pix_rgb;
        out_sof <= sof_sel;
        out_eol <= eol_sel;
      end else begin
        out_rgb <= 24'h000000;
        out_sof <= 1'b0;
        out_eol <= 1'b0;
      end
    end
  end

  lambert_shade_stream_raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .XW    (XW),
    .YW    (YW)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .advance (out_valid && out_ready),
    .x       (x_pos),
    .y       (y_pos),
    .sof     (rc_sof),
    .eol     (rc_eol)
  );

endmodule

// File: tb/tb_lambert_shade_stream.sv
// Directed bench for lambert_shade_stream, using a 4x2 raster.
module tb_lambert_shade_stream;

  localparam logic [31:0] ONE  = 32'h01000000;
  localparam logic [31:0] HALF = 32'h00800000;
  localparam logic [31:0] NEG1 = 32'hFF000000;
  localparam logic [31:0] ZERO = 32'h00000000;
  localparam logic [31:0] SQ3H = 32'h00DDB3D7;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic        hit_in;
  logic        obj_sel;
  logic [95:0] normal;
  logic [95:0] light_vec;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_rgb;
  logic        out_sof;
  logic        out_eol;

  int n_vec = 0;
  int n_err = 0;
  int pix   = 0;

  lambert_shade_stream #(.H_RES(4), .V_RES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .hit_in    (hit_in),
    .obj_sel   (obj_sel),
    .normal    (normal),
    .light_vec (light_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rgb   (out_rgb),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {x, y, z};
  endfunction

  task automatic drive_idle();
    valid_in  = 1'b0;
    hit_in    = 1'b0;
    obj_sel   = 1'b0;
    normal    = '0;
    light_vec = '0;
  endtask

  // Beat kinds: 0 lit/obj0, 1 lit/obj1, 2 miss, 3 back-facing, 4 d=0.5 via z/obj1, 5 d=0.5 via x,y/obj0
  task automatic drive_beat(input int k);
    valid_in = 1'b1;
    case (k)
      0: begin hit_in = 1'b1; obj_sel = 1'b0; normal = v3(ZERO, ZERO, ONE); light_vec = v3(ZERO, ZERO, ONE); end
      1: begin hit_in = 1'b1; obj_sel = 1'b1; normal = v3(ZERO, ZERO, ONE); light_vec = v3(ZERO, ZERO, ONE); end
      2: begin hit_in = 1'b0; obj_sel = 1'b1; normal = v3(ONE, ZERO, ZERO); light_vec = v3(ONE, ZERO, ZERO); end
      3: begin hit_in = 1'b1; obj_sel = 1'b0; normal = v3(ZERO, ZERO, ONE); light_vec = v3(ZERO, ZERO, NEG1); end
      4: begin hit_in = 1'b1; obj_sel = 1'b1; normal = v3(ZERO, ZERO, ONE); light_vec = v3(ZERO, SQ3H, HALF); end
      default: begin hit_in = 1'b1; obj_sel = 1'b0; normal = v3(HALF, HALF, ZERO); light_vec = v3(HALF, HALF, ZERO); end
    endcase
  endtask

  function automatic logic [23:0] exp_rgb(input int k);
    case (k)
      0: return 24'hFF8000;
      1: return 24'h2060FF;
      2: return 24'h101010;
      3: return 24'h190C00;
      4: return 24'h11348C;
      default: return 24'h8C4600;
    endcase
  endfunction

  // One isolated beat: checks latency, colour, markers and that nothing trails it.
  task automatic single(input int k, input string tag);
    drive_beat(k);
    #1;
    chk({tag, " ready_in"}, 32'(ready_in), 32'd1);
    tick();
    drive_idle();
    tick();
    tick();
    chk({tag, " early_valid"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " rgb"}, 32'(out_rgb), 32'(exp_rgb(k)));
    chk({tag, " sof"}, 32'(out_sof), 32'((pix % 8) == 0));
    chk({tag, " eol"}, 32'(out_eol), 32'((pix % 4) == 3));
    pix++;
    tick();
    chk({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  // Stream n beats of kinds (k0+idx)%6, with out_ready low for cycles [stall_at, stall_at+stall_len).
  task automatic run_stream(input int n, input int k0, input int stall_at, input int stall_len, input string tag);
    int b = 0;
    int j = 0;
    int cyc = 0;
    bit held = 1'b0;
    bit acc;
    logic [23:0] h_rgb;
    logic h_sof;
    logic h_eol;
    while (j < n && cyc < 100) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (b < n) drive_beat((k0 + b) % 6);
      else drive_idle();
      #1;
      if (held) begin
        chk($sformatf("%s hold_valid c%0d", tag, cyc), 32'(out_valid), 32'd1);
        chk($sformatf("%s hold_rgb c%0d", tag, cyc), 32'(out_rgb), 32'(h_rgb));
        chk($sformatf("%s hold_sof c%0d", tag, cyc), 32'(out_sof), 32'(h_sof));
        chk($sformatf("%s hold_eol c%0d", tag, cyc), 32'(out_eol), 32'(h_eol));
      end
      if (out_valid && !out_ready) begin
        chk($sformatf("%s stall_ready c%0d", tag, cyc), 32'(ready_in), 32'd0);
        h_rgb = out_rgb;
        h_sof = out_sof;
        h_eol = out_eol;
        held  = 1'b1;
      end else begin
        held = 1'b0;
      end
      acc = valid_in && ready_in;
      if (out_valid && out_ready) begin
        chk($sformatf("%s rgb%0d", tag, j), 32'(out_rgb), 32'(exp_rgb((k0 + j) % 6)));
        chk($sformatf("%s sof%0d", tag, j), 32'(out_sof), 32'((pix % 8) == 0));
        chk($sformatf("%s eol%0d", tag, j), 32'(out_eol), 32'((pix % 4) == 3));
        j++;
        pix++;
      end
      tick();
      if (acc) b++;
      cyc++;
    end
    out_ready = 1'b1;
    drive_idle();
    chk({tag, " count"}, 32'(j), 32'(n));
    chk({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    drive_idle();
    #1 rst = 1'b1;
    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_rgb", 32'(out_rgb), 32'd0);
    chk("reset out_sof", 32'(out_sof), 32'd0);
    chk("reset out_eol", 32'(out_eol), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_reset ready_in", 32'(ready_in), 32'd1);

    single(0, "lit");
    single(3, "back");
    single(2, "miss");
    single(5, "half_xy");
    single(1, "lit_obj1");

    // Reset while pixels are in flight mid-frame.
    drive_beat(0);
    tick();
    drive_beat(1);
    tick();
    drive_beat(2);
    tick();
    drive_idle();
    tick();
    chk("rst pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst async_valid", 32'(out_valid), 32'd0);
    chk("rst async_rgb", 32'(out_rgb), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    pix = 0;
    tick();
    chk("rst ready_in", 32'(ready_in), 32'd1);
    chk("rst no_stale", 32'(out_valid), 32'd0);

    run_stream(9, 1, 100, 0, "raster");
    run_stream(6, 3, 5, 4, "bp");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
